// File: rtl/rv32m_iter_unit_if.sv
// Start/busy/done handshake bundle between the EX stage
// and the iterative RV32M multiply/divide unit.
interface rv32m_iter_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/rv32m_iter_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, then a sign-fix cycle.
module rv32m_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  rv32m_iter_unit_if.slave   bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_op;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;
  logic [2*XLEN:0] r_acc;
  logic [XLEN:0]   r_mc;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_launch;
  logic            w_is_div;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN:0]   w_ma;
  logic [XLEN:0]   w_mb;
  logic            w_bz;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;
  logic            w_last;

  logic [XLEN:0]   w_addend;
  logic [XLEN:0]   w_sum;
  logic [2*XLEN:0] w_mul_step;
  logic [XLEN:0]   w_shr;
  logic [XLEN+1:0] w_sub;
  logic            w_qbit;
  logic [2*XLEN:0] w_div_step;

  logic [2*XLEN-1:0] w_mag;
  logic [2*XLEN-1:0] w_sfix;
  logic [XLEN-1:0]   w_fix_res;

  assign w_accept = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_launch = w_accept && bus.start && !bus.flush;
  assign w_is_div = bus.op[2];

  // Signed rs1: MULH, MULHSU, DIV, REM. Signed rs2: MULH, DIV, REM.
  assign w_sa = bus.a[XLEN-1] &&
                ((bus.op == 3'b001) || (bus.op == 3'b010) ||
                 (bus.op == 3'b100) || (bus.op == 3'b110));
  assign w_sb = bus.b[XLEN-1] &&
                ((bus.op == 3'b001) || (bus.op == 3'b100) ||
                 (bus.op == 3'b110));

  assign w_ma = w_sa ? -{1'b1, bus.a} : {1'b0, bus.a};
  assign w_mb = w_sb ? -{1'b1, bus.b} : {1'b0, bus.b};

  assign w_bz   = (bus.b == '0);
  assign w_ovf  = !bus.op[0] &&
                  (bus.a == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (&bus.b);
  assign w_fast = w_is_div && (w_bz || w_ovf);

  always_comb begin
    w_fast_res = '0;
    if (w_bz)
      w_fast_res = bus.op[1] ? bus.a : '1;
    else
      w_fast_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  assign w_last = (r_cnt == CW'(XLEN-1));

  // Multiply: hi holds the partial product, lo the multiplier.
  assign w_addend   = r_acc[0] ? r_mc : '0;
  assign w_sum      = r_acc[2*XLEN:XLEN] + w_addend;
  assign w_mul_step = {1'b0, w_sum, r_acc[XLEN-1:1]};

  // Divide: hi holds the remainder, lo dividend bits then quotient.
  assign w_shr      = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_sub      = {1'b0, w_shr} - {1'b0, r_mc};
  assign w_qbit     = !w_sub[XLEN+1];
  assign w_div_step = {w_qbit ? w_sub[XLEN:0] : w_shr,
                       r_acc[XLEN-2:0], w_qbit};

  always_comb begin
    w_mag = r_acc[2*XLEN-1:0];
    if (r_op[2]) begin
      if (r_op[1])
        w_mag = {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]};
      else
        w_mag = {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
    end
  end

  assign w_sfix = r_neg ? -w_mag : w_mag;

  assign w_fix_res = (r_op[2] || (r_op[1:0] == 2'b00)) ?
                     w_sfix[XLEN-1:0] : w_sfix[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_launch)
          w_next = w_fast ? S_DONE : S_CALC;
        else
          w_next = S_IDLE;
      end
      S_CALC: begin
        if (bus.flush)
          w_next = S_IDLE;
        else if (w_last)
          w_next = S_FIX;
      end
      S_FIX: begin
        w_next = bus.flush ? S_IDLE : S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mc     <= '0;
      r_result <= '0;
    end else if (w_launch) begin
      r_op  <= bus.op;
      r_cnt <= '0;
      // Remainder follows the dividend sign; all else sa^sb.
      r_neg <= (bus.op[2] && bus.op[1]) ? w_sa : (w_sa ^ w_sb);
      r_mc  <= w_is_div ? w_mb : w_ma;
      r_acc <= {{(XLEN+1){1'b0}},
                w_is_div ? w_ma[XLEN-1:0] : w_mb[XLEN-1:0]};
      if (w_fast)
        r_result <= w_fast_res;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= r_op[2] ? w_div_step : w_mul_step;
    end else if ((r_state == S_FIX) && !bus.flush) begin
      r_result <= w_fix_res;
    end
  end

  assign bus.busy   = (r_state == S_CALC) || (r_state == S_FIX);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;

endmodule

// File: tb/tb_rv32m_iter_unit.sv
// Directed bench for rv32m_iter_unit: arithmetic, fast path,
// handshake, flush, reset and back-to-back timing.
module tb_rv32m_iter_unit;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rv32m_iter_unit_if #(.XLEN(32)) ifc ();

  rv32m_iter_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    ifc.op    = op;
    ifc.a     = a;
    ifc.b     = b;
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
  endtask

  // Returns in the done cycle; lat is the cycle index after launch.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    while (!ifc.done && lat < 100) begin
      if (ifc.busy) nbusy++;
      step();
      lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int lat,
                        output int nbusy,
                        output logic [31:0] res);
    launch(op, a, b);
    wait_done(lat, nbusy);
    res = ifc.result;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    ifc.start = 1'b0;
    ifc.flush = 1'b0;
    ifc.op    = '0;
    ifc.a     = '0;
    ifc.b     = '0;
    repeat (3) step();
    rst = 1'b0;
    tests++;
    if ({ifc.busy, ifc.done, ifc.result} !== 34'b0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b result=%h, want 0/0/0",
               ifc.busy, ifc.done, ifc.result);
    end
    step();
  endtask

  task automatic test_mul_basic();
    int          lat;
    int          nb;
    logic [31:0] r;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, lat, nb, r);
    tests++;
    if (lat !== 34 || nb !== 33) begin
      fails++;
      $display("FAIL mul_timing: lat=%0d busy=%0d, want 34/33", lat, nb);
    end
    tests++;
    if (r !== 32'hFFFF_FFEB) begin
      fails++;
      $display("FAIL mul_result: got %h want FFFFFFEB", r);
    end
    step();
    tests++;
    if (ifc.done !== 1'b0 || ifc.result !== 32'hFFFF_FFEB) begin
      fails++;
      $display("FAIL done_pulse: done=%b result=%h, want 0/FFFFFFEB",
               ifc.done, ifc.result);
    end
  endtask

  task automatic test_vectors(input string name,
                              input int want_lat,
                              input logic [2:0] ops[],
                              input logic [31:0] as[],
                              input logic [31:0] bs[],
                              input logic [31:0] ex[]);
    int          lat;
    int          nb;
    logic [31:0] r;
    for (int i = 0; i < ops.size(); i++) begin
      run_op(ops[i], as[i], bs[i], lat, nb, r);
      tests++;
      if (lat !== want_lat || r !== ex[i]) begin
        fails++;
        $display("FAIL %s[%0d]: op=%0d got %h lat=%0d, want %h lat=%0d",
                 name, i, ops[i], r, lat, ex[i], want_lat);
      end
    end
    step();
  endtask

  task automatic test_mul_high();
    test_vectors("mulh", 34,
      '{3'b001, 3'b011, 3'b010, 3'b000},
      '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF},
      '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001});
  endtask

  task automatic test_divide();
    test_vectors("div", 34,
      '{3'b100, 3'b110, 3'b101, 3'b111, 3'b110},
      '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7},
      '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE},
      '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_000E,
        32'h0000_0002, 32'h0000_0001});
  endtask

  task automatic test_fast_path();
    test_vectors("fast", 1,
      '{3'b100, 3'b111, 3'b100, 3'b110},
      '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000},
      '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0});
  endtask

  task automatic test_handshake();
    int cyc;
    int ndone;
    int lat;
    int nb;
    logic [31:0] r;
    // start mid-operation must be ignored
    launch(3'b101, 32'd100, 32'd7);
    repeat (9) step();
    ifc.op    = 3'b000;
    ifc.a     = 32'd3;
    ifc.b     = 32'd4;
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    cyc = 11;
    while (!ifc.done && cyc < 100) begin
      step();
      cyc++;
    end
    tests++;
    if (cyc !== 34 || ifc.result !== 32'd14) begin
      fails++;
      $display("FAIL start_ignored: cyc=%0d result=%h, want 34/0000000E",
               cyc, ifc.result);
    end
    step();
    // flush during CALC
    launch(3'b000, 32'd3, 32'd4);
    repeat (11) step();
    ifc.flush = 1'b1;
    step();
    ifc.flush = 1'b0;
    tests++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      fails++;
      $display("FAIL flush_busy: busy=%b done=%b, want 0/0",
               ifc.busy, ifc.done);
    end
    ndone = 0;
    repeat (40) begin
      step();
      if (ifc.done) ndone++;
    end
    tests++;
    if (ndone !== 0 || ifc.result !== 32'd14) begin
      fails++;
      $display("FAIL flush_nodone: dones=%0d result=%h, want 0/0000000E",
               ndone, ifc.result);
    end
    // flush and start together in IDLE
    ifc.flush = 1'b1;
    ifc.start = 1'b1;
    step();
    ifc.flush = 1'b0;
    ifc.start = 1'b0;
    tests++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      fails++;
      $display("FAIL flush_start: busy=%b done=%b, want 0/0",
               ifc.busy, ifc.done);
    end
    // flush in DONE: pulse survives, no relaunch
    run_op(3'b101, 32'd100, 32'd7, lat, nb, r);
    ifc.flush = 1'b1;
    ifc.start = 1'b1;
    #1;
    tests++;
    if (ifc.done !== 1'b1 || r !== 32'd14) begin
      fails++;
      $display("FAIL flush_done_pulse: done=%b result=%h, want 1/0000000E",
               ifc.done, r);
    end
    step();
    ifc.flush = 1'b0;
    ifc.start = 1'b0;
    tests++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      fails++;
      $display("FAIL flush_done_next: busy=%b done=%b, want 0/0",
               ifc.busy, ifc.done);
    end
    // reset mid-operation
    launch(3'b000, 32'd3, 32'd4);
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if ({ifc.busy, ifc.done, ifc.result} !== 34'b0) begin
      fails++;
      $display("FAIL rst_abort: busy=%b done=%b result=%h, want 0/0/0",
               ifc.busy, ifc.done, ifc.result);
    end
    ndone = 0;
    repeat (40) begin
      step();
      if (ifc.done) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL rst_nodone: dones=%0d want 0", ndone);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    int          nb;
    logic [31:0] r;
    run_op(3'b101, 32'd100, 32'd7, lat, nb, r);
    tests++;
    if (lat !== 34 || r !== 32'd14) begin
      fails++;
      $display("FAIL b2b_first: lat=%0d result=%h, want 34/0000000E",
               lat, r);
    end
    launch(3'b000, 32'd3, 32'd4);
    wait_done(lat, nb);
    tests++;
    if (lat !== 34 || nb !== 33 || ifc.result !== 32'd12) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d busy=%0d result=%h, want 34/33/0000000C",
               lat, nb, ifc.result);
    end
    step();
    tests++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_dup: done=%b busy=%b, want 0/0",
               ifc.done, ifc.busy);
    end
  endtask

  initial begin
    rst       = 1'b1;
    ifc.start = 1'b0;
    ifc.flush = 1'b0;
    ifc.op    = '0;
    ifc.a     = '0;
    ifc.b     = '0;
    test_reset();
    test_mul_basic();
    test_mul_high();
    test_divide();
    test_fast_path();
    test_handshake();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
